// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 32-bit RAM port between instruction fetch (I, read-only) and
//   load/store (D, read/write with byte enables). Round-robin between the two
//   requesters, decided only in IDLE. Partial-word stores are carried out as
//   read-modify-write because the RAM port writes whole words only.
//
//   Handshake: a requester raises *_req with its fields and holds all of them
//   stable until *_ack, a one-cycle pulse. rdata/err are valid only while
//   *_ack is high. The requester may raise req again in the cycle after ack.
//
//   Ports
//     m_clock, p_reset           clock (rising edge), async active-low reset
//     i_req/i_addr               fetch request
//     i_ack/i_rdata              fetch completion and data
//     d_req/d_we/d_addr/d_wdata/d_be   load/store request
//     d_ack/d_rdata/d_err        load/store completion, data and error
//     ram_addr/ram_wdata/ram_we  RAM port (address always word aligned)
//     ram_rdata                  RAM read data, combinational from ram_addr
//     busy                       high whenever the FSM is not in IDLE
//
//   Optional feature: define MEM_RANGE_CHECK_EN to reject accesses whose
//   aligned address lies above MEM_CAPACITY-4 without touching the RAM.
module mem_port_arbiter #(
    parameter int unsigned MEM_CAPACITY = 4096
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam logic [31:0] NOP_WORD       = 32'h0000_0013;
    localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_CAPACITY) - 32'd4;
`ifdef MEM_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;   // 1: the most recent grant went to D
    logic        gnt_d_q, gnt_d_d;     // 1: the access in flight belongs to D
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        i_ack_q, i_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        ram_we_q, ram_we_d;
    logic        busy_q, busy_d;

    logic [31:0] i_addr_al, d_addr_al;
    logic        i_oob, d_oob, pick_i, pick_d, ram_access;

    assign i_addr_al = i_addr & 32'hFFFF_FFFC;
    assign d_addr_al = d_addr & 32'hFFFF_FFFC;
    assign i_oob     = RANGE_EN && (i_addr_al > LAST_WORD_ADDR);
    assign d_oob     = RANGE_EN && (d_addr_al > LAST_WORD_ADDR);

    // On a tie the requester that did not win last time gets the port.
    assign pick_i = i_req && (!d_req || last_d_q);
    assign pick_d = d_req && !pick_i;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        gnt_d_d  = gnt_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        be_d     = be_q;
        we_d     = we_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_i) begin
                    gnt_d_d  = 1'b0;
                    last_d_d = 1'b0;
                    addr_d   = i_addr_al;
                    wdata_d  = 32'd0;
                    be_d     = 4'd0;
                    we_d     = 1'b0;
                    err_d    = 1'b0;
                    // An out-of-range fetch returns a NOP instead of reading.
                    rdata_d  = i_oob ? NOP_WORD : 32'd0;
                    state_d  = i_oob ? ST_ACK : ST_RD;
                end else if (pick_d) begin
                    gnt_d_d  = 1'b1;
                    last_d_d = 1'b1;
                    addr_d   = d_addr_al;
                    wdata_d  = d_wdata;
                    be_d     = d_be;
                    we_d     = d_we;
                    err_d    = d_oob;
                    rdata_d  = 32'd0;
                    if (d_oob || (d_we && d_be == 4'h0)) begin
                        state_d = ST_ACK;
                    end else if (!d_we) begin
                        state_d = ST_RD;
                    end else if (d_be == 4'hF) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = ram_rdata;
                state_d = ST_ACK;
            end
            ST_RMW_RD: begin
                // Merge enabled store lanes over the current RAM word.
                for (int n = 0; n < 4; n++) begin
                    wdata_d[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : ram_rdata[8*n +: 8];
                end
                state_d = ST_WR;
            end
            ST_WR:   state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the state being entered.
        ram_access  = (state_d == ST_RD) || (state_d == ST_RMW_RD) || (state_d == ST_WR);
        ram_addr_d  = ram_access ? addr_d : 32'd0;
        ram_we_d    = (state_d == ST_WR);
        ram_wdata_d = (state_d == ST_WR) ? wdata_d : 32'd0;
        i_ack_d     = (state_d == ST_ACK) && !gnt_d_d;
        d_ack_d     = (state_d == ST_ACK) && gnt_d_d;
        i_rdata_d   = i_ack_d ? rdata_d : 32'd0;
        d_rdata_d   = (d_ack_d && !we_d) ? rdata_d : 32'd0;
        d_err_d     = d_ack_d && err_d;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q     <= ST_IDLE;
            last_d_q    <= 1'b1;
            gnt_d_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            be_q        <= 4'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_err_q     <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            gnt_d_q     <= gnt_d_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            err_q       <= err_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: RAM model, transaction-level reference
// model producing per-cycle expectations, directed and randomized stimulus.
module tb_mem_port_arbiter;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_be = 4'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        busy;

    mem_port_arbiter #(.MEM_CAPACITY(4096)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // ---------------- clock ----------------
    initial forever #5 m_clock = ~m_clock;

    // ---------------- RAM and shadow memory ----------------
    logic [31:0] tb_ram  [0:1023];
    logic [31:0] ref_mem [0:1023];
    assign ram_rdata = tb_ram[ram_addr[11:2]];

    initial forever begin
        @(posedge m_clock);
        if (ram_we) tb_ram[ram_addr[11:2]] = ram_wdata;
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        tb_ram[a[11:2]]  = v;
        ref_mem[a[11:2]] = v;
    endtask

    // ---------------- reference model ----------------
    // Each queued entry is what the outputs must show during one cycle of a
    // transaction; an empty queue means an IDLE cycle (all outputs zero).
    typedef struct packed {
        logic        busy;
        logic        i_ack;
        logic [31:0] i_rdata;
        logic        d_ack;
        logic [31:0] d_rdata;
        logic        d_err;
        logic [31:0] ram_addr;
        logic        ram_we;
        logic [31:0] ram_wdata;
    } exp_t;

    exp_t exp_q[$];
    logic last_was_d = 1'b1;

`ifdef MEM_RANGE_CHECK_EN
    localparam bit TB_RANGE_EN = 1'b1;
`else
    localparam bit TB_RANGE_EN = 1'b0;
`endif

    task automatic push_access(input logic [31:0] a, input logic we, input logic [31:0] wd);
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        e.ram_addr = a;
        e.ram_we = we;
        e.ram_wdata = we ? wd : 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic model_grant();
        exp_t        e;
        logic [31:0] a, old_w, merged;
        e = '0;
        e.busy = 1'b1;
        if (i_req && (!d_req || last_was_d)) begin
            last_was_d = 1'b0;
            a = i_addr & 32'hFFFF_FFFC;
            e.i_ack = 1'b1;
            if (TB_RANGE_EN && a > 32'hFFC) begin
                e.i_rdata = 32'h0000_0013;
            end else begin
                push_access(a, 1'b0, 32'd0);
                e.i_rdata = ref_mem[a[11:2]];
            end
            exp_q.push_back(e);
        end else if (d_req) begin
            last_was_d = 1'b1;
            a = d_addr & 32'hFFFF_FFFC;
            old_w = ref_mem[a[11:2]];
            e.d_ack = 1'b1;
            if (TB_RANGE_EN && a > 32'hFFC) begin
                e.d_err = 1'b1;
            end else if (!d_we) begin
                push_access(a, 1'b0, 32'd0);
                e.d_rdata = old_w;
            end else if (d_be == 4'hF) begin
                push_access(a, 1'b1, d_wdata);
            end else if (d_be != 4'h0) begin
                for (int n = 0; n < 4; n++)
                    merged[8*n +: 8] = d_be[n] ? d_wdata[8*n +: 8] : old_w[8*n +: 8];
                push_access(a, 1'b0, 32'd0);
                push_access(a, 1'b1, merged);
            end
            exp_q.push_back(e);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge m_clock or negedge p_reset);
        if (!p_reset) begin
            exp_q.delete();
            last_was_d = 1'b1;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.ram_we) ref_mem[e.ram_addr[11:2]] = e.ram_wdata;
        end else begin
            model_grant();
        end
    end

    // ---------------- per-cycle compare ----------------
    int order_q[$];
    initial forever begin
        exp_t cur;
        @(negedge m_clock);
        cur = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("busy",      {31'd0, busy},   {31'd0, cur.busy});
        chk("i_ack",     {31'd0, i_ack},  {31'd0, cur.i_ack});
        chk("i_rdata",   i_rdata,         cur.i_rdata);
        chk("d_ack",     {31'd0, d_ack},  {31'd0, cur.d_ack});
        chk("d_rdata",   d_rdata,         cur.d_rdata);
        chk("d_err",     {31'd0, d_err},  {31'd0, cur.d_err});
        chk("ram_addr",  ram_addr,        cur.ram_addr);
        chk("ram_we",    {31'd0, ram_we}, {31'd0, cur.ram_we});
        chk("ram_wdata", ram_wdata,       cur.ram_wdata);
        chk("ack_overlap", {31'd0, i_ack & d_ack}, 32'd0);
        if (i_ack) order_q.push_back(0);
        if (d_ack) order_q.push_back(1);
    end

    // ---------------- driver tasks ----------------
    // Called at #1 after a rising edge; return at #1 after the edge that
    // follows the ack, with the request dropped.
    task automatic do_i(input logic [31:0] a, output logic [31:0] rd,
                        output int lat, output logic [31:0] seen_addr);
        bit got;
        got = 1'b0; rd = 32'd0; lat = 0; seen_addr = 32'd0;
        i_req = 1'b1; i_addr = a;
        for (int k = 0; k < 60; k++) begin
            @(negedge m_clock);
            if (i_ack) begin rd = i_rdata; got = 1'b1; break; end
            if (ram_addr != 32'd0 && seen_addr == 32'd0) seen_addr = ram_addr;
            lat++;
        end
        if (!got) chk("i_ack_timeout", 32'd0, 32'd1);
        @(posedge m_clock); #1;
        i_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output int lat, output int wcnt, output logic [31:0] wval,
                        output logic [31:0] seen_addr);
        bit got;
        got = 1'b0; rd = 32'd0; err = 1'b0; lat = 0; wcnt = 0; wval = 32'd0; seen_addr = 32'd0;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        for (int k = 0; k < 60; k++) begin
            @(negedge m_clock);
            if (d_ack) begin rd = d_rdata; err = d_err; got = 1'b1; break; end
            if (ram_we) begin wcnt++; wval = ram_wdata; end
            if (ram_addr != 32'd0 && seen_addr == 32'd0) seen_addr = ram_addr;
            lat++;
        end
        if (!got) chk("d_ack_timeout", 32'd0, 32'd1);
        @(posedge m_clock); #1;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        p_reset = 1'b0;
        repeat (3) @(posedge m_clock);
        #1 p_reset = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd, wv, sa;
        logic        er;
        int          lat, wc;

        for (int k = 0; k < 1024; k++) begin
            tb_ram[k]  = $urandom;
            ref_mem[k] = tb_ram[k];
        end

        #2 p_reset = 1'b0;
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        chk("rst_busy",     {31'd0, busy},   32'd0);
        chk("rst_i_ack",    {31'd0, i_ack},  32'd0);
        chk("rst_d_ack",    {31'd0, d_ack},  32'd0);
        chk("rst_ram_we",   {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", ram_addr,        32'd0);
        @(posedge m_clock); #1 p_reset = 1'b1;

        // Fetch read with unaligned address.
        poke(32'h100, 32'hDEADBEEF);
        do_i(32'h102, rd, lat, sa);
        chk("fetch_data", rd, 32'hDEADBEEF);
        chk("fetch_lat",  lat, 32'd2);
        chk("fetch_addr", sa, 32'h100);

        // Partial store via read-modify-write.
        poke(32'h40, 32'h11223344);
        do_d(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, lat, wc, wv, sa);
        chk("rmw_wcnt",  wc, 32'd1);
        chk("rmw_wdata", wv, 32'h11BB33DD);
        chk("rmw_lat",   lat, 32'd3);
        chk("rmw_ram",   tb_ram[32'h40 >> 2], 32'h11BB33DD);

        // Full-word store then load back.
        do_d(1'b1, 32'h200, 32'h0BADF00D, 4'hF, rd, er, lat, wc, wv, sa);
        chk("full_wcnt", wc, 32'd1);
        chk("full_lat",  lat, 32'd2);
        do_d(1'b0, 32'h203, 32'h0, 4'h0, rd, er, lat, wc, wv, sa);
        chk("load_data", rd, 32'h0BADF00D);
        chk("load_lat",  lat, 32'd2);
        chk("load_err",  {31'd0, er}, 32'd0);

        // Zero-enable store: ack with no RAM access.
        poke(32'h44, 32'h5A5A5A5A);
        do_d(1'b1, 32'h44, 32'hFFFFFFFF, 4'h0, rd, er, lat, wc, wv, sa);
        chk("be0_lat",  lat, 32'd1);
        chk("be0_wcnt", wc, 32'd0);
        chk("be0_ram",  tb_ram[32'h44 >> 2], 32'h5A5A5A5A);

        // Range boundary.
        poke(32'hFFC, 32'hCAFE0FFC);
`ifdef MEM_RANGE_CHECK_EN
        do_d(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, wc, wv, sa);
        chk("oob_err",  {31'd0, er}, 32'd1);
        chk("oob_data", rd, 32'd0);
        chk("oob_lat",  lat, 32'd1);
        chk("oob_addr", sa, 32'd0);
        do_i(32'h1004, rd, lat, sa);
        chk("oob_fetch_nop", rd, 32'h00000013);
`else
        poke(32'h0, 32'h00C0FFEE);
        do_d(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, wc, wv, sa);
        chk("pass_err",  {31'd0, er}, 32'd0);
        chk("pass_data", rd, 32'h00C0FFEE);
`endif
        do_d(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat, wc, wv, sa);
        chk("edge_err",  {31'd0, er}, 32'd0);
        chk("edge_data", rd, 32'hCAFE0FFC);
        chk("edge_lat",  lat, 32'd2);

        // Contention from reset release: grants must alternate I, D, I, D.
        do_reset();
        order_q.delete();
        fork
            begin
                logic [31:0] r1, s1;
                int l1;
                for (int k = 0; k < 3; k++) do_i(32'h300 + 32'(k * 4), r1, l1, s1);
            end
            begin
                logic [31:0] r2, w2, s2;
                logic e2;
                int l2, c2;
                do_d(1'b0, 32'h310, 32'h0, 4'h0, r2, e2, l2, c2, w2, s2);
                do_d(1'b1, 32'h314, 32'h12345678, 4'hF, r2, e2, l2, c2, w2, s2);
                do_d(1'b0, 32'h314, 32'h0, 4'h0, r2, e2, l2, c2, w2, s2);
            end
        join
        chk("order_len", order_q.size(), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("order", (k < order_q.size()) ? order_q[k] : 32'hFFFF, 32'(k % 2));

        // Randomized traffic from both requesters.
        fork
            begin
                logic [31:0] r1, s1, a1;
                int l1;
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge m_clock); #1; end
                    a1 = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 15)
                                                     : $urandom_range(0, 4095);
                    do_i(a1, r1, l1, s1);
                end
            end
            begin
                logic [31:0] r2, w2, s2, a2;
                logic [3:0]  b2;
                logic        e2;
                int l2, c2, sel;
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge m_clock); #1; end
                    a2 = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 15)
                                                     : $urandom_range(0, 4095);
                    sel = $urandom_range(0, 3);
                    b2 = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                    do_d(1'($urandom_range(0, 1)), a2, $urandom, b2, r2, e2, l2, c2, w2, s2);
                end
            end
        join

        // Reset while in RMW_RD: the write must never happen.
        poke(32'h40, 32'h11223344);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55667788; d_be = 4'b0011;
        @(posedge m_clock); #1;
        chk("rmw_rd_busy", {31'd0, busy}, 32'd1);
        chk("rmw_rd_addr", ram_addr, 32'h40);
        p_reset = 1'b0;
        d_req = 1'b0;
        #1;
        chk("abort_ram_we",   {31'd0, ram_we}, 32'd0);
        chk("abort_busy",     {31'd0, busy},   32'd0);
        chk("abort_ram_addr", ram_addr,        32'd0);
        repeat (3) @(posedge m_clock);
        chk("abort_ram_word", tb_ram[32'h40 >> 2], 32'h11223344);
        #1 p_reset = 1'b1;
        do_i(32'h40, rd, lat, sa);
        chk("post_rst_fetch", rd, 32'h11223344);
        chk("post_rst_lat",   lat, 32'd2);

        // Whole RAM image must match the model's shadow memory.
        wc = 0;
        for (int k = 0; k < 1024; k++) if (tb_ram[k] !== ref_mem[k]) wc++;
        chk("ram_image", wc, 32'd0);

        repeat (2) @(posedge m_clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit port of the dual-port RAM between two requesters: instruction fetch (I, read-only) and load/store (D, read/write with byte enables).
- Round-robin arbitration with a req/ack handshake.
- Sub-word D stores are done as a read-modify-write sequence, because the RAM port only takes full 32-bit writes.
- Sits between the core's fetch/LSU units and the RAM port.

Parameters:
- MEM_CAPACITY, 4096: RAM size in bytes. Used only by the optional range check.

Ports:
- m_clock  in  1  system clock, rising edge.
- p_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request. Held high until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle completion pulse for fetch.
- i_rdata  out  32  fetch data. Valid while i_ack=1.
- d_req  in  1  load/store request. Held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  load/store byte address.
- d_wdata  in  32  store data, lane-aligned.
- d_be  in  4  store byte enables; bit n covers lane [8n+7:8n].
- d_ack  out  1  one-cycle completion pulse for load/store.
- d_rdata  out  32  load data. Valid while d_ack=1.
- d_err  out  1  access error. Valid while d_ack=1.
- ram_addr  out  32  RAM port address. Bits [1:0] always 0.
- ram_wdata  out  32  RAM port write data.
- ram_we  out  1  RAM port write strobe.
- ram_rdata  in  32  RAM port read data (combinational from ram_addr).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (p_reset=0, asynchronous):
  - state=IDLE, last_grant=D (so I wins the first tie).
  - All outputs 0. Latched addr/data/be/we cleared.
  - Reset during RD/WR aborts the access: ram_we drops immediately; no partial write occurs after reset asserts.
- Requester rule: a requester holds req, addr, wdata, be and we stable until its ack. It may re-assert req in the cycle after ack.
- Arbitration, in IDLE only:
  - One requester pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - On grant, latch the request fields with addr[1:0] cleared, and set last_grant.
- States:
  - IDLE:
    - No request: stay.
    - I granted, or D granted with d_we=0: go to RD.
    - D store with d_be=4'hF: go to WR.
    - D store with d_be=4'h0: go to ACK (no RAM access).
    - D store with any other d_be: go to RMW_RD.
  - RD: ram_addr=latched addr, ram_we=0. Capture ram_rdata into the rdata register. Go to ACK.
  - RMW_RD: ram_addr=latched addr. Capture merged word into the wdata register: byte n = be[n] ? wdata byte n : ram_rdata byte n. Go to WR.
  - WR: ram_addr=latched addr, ram_wdata=wdata register, ram_we=1 for exactly this cycle. Go to ACK.
  - ACK: pulse the granted requester's ack for one cycle. rdata output = captured word (0 for stores). Go to IDLE.
- Latency, from the grant edge to ack high:
  - Load/fetch: 2 cycles.
  - Full-word store: 2 cycles.
  - Partial store: 3 cycles.
  - be=0 store: 1 cycle.
- Throughput: one access per (latency+1) cycles, because IDLE is always revisited.
- Outputs outside their states: ram_we=0; ram_addr/ram_wdata=0 in IDLE. Non-granted ack stays 0.
- Fairness: when both requesters continuously request, grants alternate I, D, I, D.
- Address wrap: no wrap arithmetic inside the block; the RAM port receives the aligned address unchanged.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: a D access with aligned addr > MEM_CAPACITY-4 skips the RAM entirely (IDLE goes directly to ACK). It acks with d_err=1 and d_rdata=0, and ram_we is never asserted. An I access out of range acks with i_rdata=32'h00000013 (NOP) and no RAM read.
- Not defined: no check; d_err tied 0; every address is passed through.

Test Plan:
- Fetch read: RAM word 0x100 = 32'hDEADBEEF; i_req, i_addr=0x102 → ram_addr=0x100, i_ack 2 cycles after grant, i_rdata=32'hDEADBEEF.
- Partial store: word 0x40 = 32'h11223344; d_we=1, d_be=4'b0101, d_wdata=32'hAABBCCDD → one ram_we pulse writing 32'h11BB33DD, d_ack 3 cycles after grant.
- Contention: i_req and d_req both held from reset release → grants I, D, I, D; ack pulses never overlap; ram_we only on D full-word store grants.
- Reset mid-RMW: assert p_reset in RMW_RD → ram_we never pulses, outputs 0; word 0x40 unchanged; after release, a new fetch completes normally.
- Zero-enable store: d_we=1, d_be=0 → d_ack 1 cycle after grant, no ram_we.
- Range check with MEM_RANGE_CHECK_EN, MEM_CAPACITY=4096: d load at 0x1000 → d_ack with d_err=1, d_rdata=0, no RAM access. At 0xFFC → normal read, d_err=0.
